// File: rtl/reclock_detect.sv
// Frequency detector for the ReClock divided-clock line: measures the period of
// a same-clock square wave, recovers its 2-bit code and reports lock and errors.
module reclock_detect #(
    parameter int unsigned HALF_0 = 1,
    parameter int unsigned HALF_1 = 2,
    parameter int unsigned HALF_2 = 4,
    parameter int unsigned HALF_3 = 8,
    parameter int unsigned TOL    = 0,
    parameter int unsigned LOCK_N = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic             enable,
    input  logic             in,
    output logic [1:0]       frecuency,
    output logic             valid,
    output logic             error,
    output logic [CNT_W-1:0] period
);

    localparam int unsigned      MW      = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEAS,
        S_LOCK
    } state_e;

    state_e           state_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             edge_q;
    logic [CNT_W-1:0] cnt_q;
    logic [MW-1:0]    match_q;
    logic [1:0]       cand_q;
    logic [1:0]       freq_q;
    logic             valid_q;
    logic             error_q;
    logic [CNT_W-1:0] period_q;

    logic             rise_c;
    logic [3:0]       hit_c;
    logic             any_c;
    logic [1:0]       code_c;
    logic [MW-1:0]    match_inc_c;

    // True when measured period p lies within TOL of the full period 2*half.
    function automatic logic near(input logic [CNT_W-1:0] p, input int unsigned half);
        int d;
        d = int'(p) - int'(2 * half);
        return (d <= int'(TOL)) && (-d <= int'(TOL));
    endfunction

    assign rise_c = sync2_q & ~edge_q;

    // Classify the running count; lowest code wins on overlapping windows.
    always_comb begin
        hit_c       = {near(cnt_q, HALF_3), near(cnt_q, HALF_2),
                       near(cnt_q, HALF_1), near(cnt_q, HALF_0)};
        any_c       = |hit_c;
        code_c      = 2'd3;
        if (hit_c[2]) code_c = 2'd2;
        if (hit_c[1]) code_c = 2'd1;
        if (hit_c[0]) code_c = 2'd0;
        match_inc_c = match_q + MW'(1);
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q  <= S_IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            edge_q   <= 1'b0;
            cnt_q    <= '0;
            match_q  <= '0;
            cand_q   <= 2'd0;
            freq_q   <= 2'd0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            period_q <= '0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            error_q <= 1'b0;
            if (!enable) begin
                state_q <= S_IDLE;
                valid_q <= 1'b0;
                cnt_q   <= '0;
                match_q <= '0;
            end else if (state_q == S_IDLE) begin
                state_q <= S_ARM;
                cnt_q   <= '0;
                match_q <= '0;
            end else if (rise_c) begin
                cnt_q <= CNT_W'(1);
                case (state_q)
                    S_ARM: state_q <= S_MEAS;
                    S_MEAS: begin
                        period_q <= cnt_q;
                        if (!any_c) begin
                            error_q <= 1'b1;
                            match_q <= '0;
                        end else if (code_c == cand_q) begin
                            match_q <= match_inc_c;
                            if (match_inc_c >= MW'(LOCK_N)) begin
                                freq_q  <= code_c;
                                valid_q <= 1'b1;
                                state_q <= S_LOCK;
                            end
                        end else begin
                            cand_q  <= code_c;
                            match_q <= MW'(1);
                        end
                    end
                    S_LOCK: begin
                        period_q <= cnt_q;
                        if (!any_c || (code_c != freq_q)) begin
                            valid_q <= 1'b0;
                            state_q <= S_MEAS;
                            if (any_c) begin
                                cand_q  <= code_c;
                                match_q <= MW'(1);
                            end else begin
                                error_q <= 1'b1;
                                match_q <= '0;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (cnt_q == CNT_PRE) begin
                // Reaching saturation is a one-shot timeout; a saturated count stays silent.
                cnt_q   <= CNT_MAX;
                error_q <= 1'b1;
                valid_q <= 1'b0;
                match_q <= '0;
                state_q <= S_ARM;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign frecuency = freq_q;
    assign valid     = valid_q;
    assign error     = error_q;
    assign period    = period_q;

endmodule
